ecc_apb_master: RTL

APB write initiator that drives the EncDec ECC slave register block on behalf of a local command port. For each accepted command it programs the CODEWORD_WIDTH, DATA_IN, NOISE and CTRL registers over APB, with CTRL written last because that write starts the operation. It then waits for `operation_done` and returns `data_out` and `num_of_errors`, or a timeout, on a response handshake. It sits between a test or host sequencer and the EncDec top-level.

---
 rtl/ecc_apb_pkg.sv | 34 +++
 rtl/apb_seq_rom.sv | 45 ++++
 rtl/ecc_apb_master.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ecc_apb_pkg.sv
// Shared constants and types for the EncDec ECC APB write initiator.
// Register map, opcodes, width codes, FSM states and sequence index.
package ecc_apb_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_DATA_IN  = 8'h04;
    localparam logic [7:0] OFF_CW_WIDTH = 8'h08;
    localparam logic [7:0] OFF_NOISE    = 8'h0C;

    localparam logic [1:0] OP_ENC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_FULL = 2'b10;

    localparam logic [1:0] W_8  = 2'b00;
    localparam logic [1:0] W_16 = 2'b01;
    localparam logic [1:0] W_32 = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    typedef logic [1:0] reg_idx_t;

    // CTRL is last: writing it starts the slave
    localparam reg_idx_t IDX_WIDTH = 2'd0;
    localparam reg_idx_t IDX_DATA  = 2'd1;
    localparam reg_idx_t IDX_NOISE = 2'd2;
    localparam reg_idx_t IDX_CTRL  = 2'd3;

endpackage

// File: rtl/apb_seq_rom.sv
// Maps a write-sequence index to its APB address and write data.
// Purely combinational; the caller selects the command source.
import ecc_apb_pkg::*;

module apb_seq_rom #(
    parameter int          AW        = 20,
    parameter int          DW        = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  reg_idx_t        idx_i,
    input  logic [1:0]      op_i,
    input  logic [1:0]      width_i,
    input  logic [DW-1:0]   data_i,
    input  logic [DW-1:0]   noise_i,
    output logic [AW-1:0]   addr_o,
    output logic [DW-1:0]   wdata_o
);

    logic [7:0] off;

    always_comb begin
        off     = '0;
        wdata_o = '0;
        unique case (idx_i)
            IDX_WIDTH: begin
                off     = OFF_CW_WIDTH;
                wdata_o = DW'(width_i);
            end
            IDX_DATA: begin
                off     = OFF_DATA_IN;
                wdata_o = data_i;
            end
            IDX_NOISE: begin
                off     = OFF_NOISE;
                wdata_o = noise_i;
            end
            IDX_CTRL: begin
                off     = OFF_CTRL;
                wdata_o = DW'(op_i);
            end
        endcase
        addr_o = AW'(BASE_ADDR + 32'(off));
    end

endmodule

// File: rtl/ecc_apb_master.sv
// APB write initiator for the EncDec ECC slave: programs four registers,
// waits for operation_done (or a timeout) and returns a response.
import ecc_apb_pkg::*;

module ecc_apb_master #(
    parameter int          AMBA_ADDR_WIDTH = 20,
    parameter int          AMBA_WORD       = 32,
    parameter int          DATA_WIDTH      = 32,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int          TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [1:0]                 cmd_width,
    input  logic [AMBA_WORD-1:0]       cmd_data,
    input  logic [AMBA_WORD-1:0]       cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_errors,
    output logic                       rsp_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                       state_q;
    reg_idx_t                     idx_q;
    reg_idx_t                     idx_d;
    logic [CW-1:0]                cnt_q;
    logic [1:0]                   op_q;
    logic [1:0]                   width_q;
    logic [AMBA_WORD-1:0]         data_q;
    logic [AMBA_WORD-1:0]         noise_q;
    logic                         cmd_ready_q;
    logic [AMBA_ADDR_WIDTH-1:0]   paddr_q;
    logic [AMBA_WORD-1:0]         pwdata_q;
    logic                         psel_q;
    logic                         penable_q;
    logic                         pwrite_q;
    logic                         rsp_valid_q;
    logic [DATA_WIDTH-1:0]        rsp_data_q;
    logic [1:0]                   rsp_errors_q;
    logic                         rsp_timeout_q;

    logic [1:0]                   rom_op;
    logic [1:0]                   rom_width;
    logic [AMBA_WORD-1:0]         rom_data;
    logic [AMBA_WORD-1:0]         rom_noise;
    logic [AMBA_ADDR_WIDTH-1:0]   rom_addr;
    logic [AMBA_WORD-1:0]         rom_wdata;
    logic                         prdata_unused;

    assign prdata_unused = ^PRDATA;

    // In IDLE the first register is loaded straight from the command port
    always_comb begin
        idx_d     = (state_q == S_IDLE) ? IDX_WIDTH : idx_q + 2'd1;
        rom_op    = (state_q == S_IDLE) ? cmd_op    : op_q;
        rom_width = (state_q == S_IDLE) ? cmd_width : width_q;
        rom_data  = (state_q == S_IDLE) ? cmd_data  : data_q;
        rom_noise = (state_q == S_IDLE) ? cmd_noise : noise_q;
    end

    apb_seq_rom #(
        .AW        (AMBA_ADDR_WIDTH),
        .DW        (AMBA_WORD),
        .BASE_ADDR (BASE_ADDR)
    ) u_rom (
        .idx_i   (idx_d),
        .op_i    (rom_op),
        .width_i (rom_width),
        .data_i  (rom_data),
        .noise_i (rom_noise),
        .addr_o  (rom_addr),
        .wdata_o (rom_wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            idx_q         <= IDX_WIDTH;
            cnt_q         <= '0;
            op_q          <= '0;
            width_q       <= '0;
            data_q        <= '0;
            noise_q       <= '0;
            cmd_ready_q   <= 1'b1;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_errors_q  <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= cmd_op;
                        width_q     <= cmd_width;
                        data_q      <= cmd_data;
                        noise_q     <= cmd_noise;
                        idx_q       <= idx_d;
                        cmd_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b1;
                        paddr_q     <= rom_addr;
                        pwdata_q    <= rom_wdata;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (idx_q == IDX_CTRL) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        paddr_q   <= '0;
                        pwdata_q  <= '0;
                        cnt_q     <= '0;
                        state_q   <= S_WAIT_DONE;
                    end else begin
                        idx_q     <= idx_d;
                        penable_q <= 1'b0;
                        paddr_q   <= rom_addr;
                        pwdata_q  <= rom_wdata;
                        state_q   <= S_SETUP;
                    end
                end
                S_WAIT_DONE: begin
                    if (operation_done) begin
                        rsp_data_q    <= data_out;
                        rsp_errors_q  <= num_of_errors;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                        rsp_data_q    <= '0;
                        rsp_errors_q  <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_errors  = rsp_errors_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
